// File: rtl/mac_dot_seq_pkg.sv
// Shared definitions for the dot-product sequencer and other MAC clients:
// op encodings, FSM states, pipeline latency and guard-bit lane layout.
package mac_dot_seq_pkg;

   localparam int MAC_LAT_DEF = 3;

   localparam logic [1:0] OP_CLR  = 2'b00;
   localparam logic [1:0] OP_LOAD = 2'b01;
   localparam logic [1:0] OP_ACC  = 2'b10;
   localparam logic [1:0] OP_SAT  = 2'b11;

   // Dual 8x8 mode splits the 40-bit accumulator into two 20-bit lanes
   localparam int LANE_W          = 16;
   localparam int GUARD_W         = 4;
   localparam int LANE0_GUARD_LSB = 0;
   localparam int LANE1_GUARD_LSB = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ACC,
      S_SAT,
      S_WAIT
   } state_t;

   function automatic logic ovf_calc(input logic       mode,
                                     input logic [31:0] res,
                                     input logic [7:0]  prot);
      logic ovf;
      logic ovf0;
      logic ovf1;
      ovf0 = (prot[LANE0_GUARD_LSB +: GUARD_W] != {GUARD_W{res[LANE_W-1]}});
      ovf1 = (prot[LANE1_GUARD_LSB +: GUARD_W] != {GUARD_W{res[2*LANE_W-1]}});
      if (!mode)
         ovf = (prot != {8{res[31]}});
      else
         ovf = ovf0 | ovf1;
      return ovf;
   endfunction

endpackage

// File: rtl/mac_dot_seq_if.sv
// Command, operand-stream, MAC-port and status bundle of the dot-product sequencer.
// The slave modport is the sequencer's view; master is the surrounding environment.
interface mac_dot_seq_if #(parameter int LEN_W = 8);

   logic             start;
   logic [LEN_W-1:0] len;
   logic             mode;
   logic             sat;
   logic             in_valid;
   logic             in_ready;
   logic [15:0]      in_a;
   logic [15:0]      in_b;

   logic [2:0]       mac_instruction;
   logic [15:0]      mac_multiplier;
   logic [15:0]      mac_multiplicand;
   logic             mac_stall;
   logic [31:0]      mac_result;
   logic [7:0]       mac_protect;

   logic             busy;
   logic             done;
   logic [31:0]      dot_result;
   logic [7:0]       dot_protect;
   logic             dot_overflow;

   modport slave (
      input  start, len, mode, sat, in_valid, in_a, in_b,
      input  mac_result, mac_protect,
      output in_ready,
      output mac_instruction, mac_multiplier, mac_multiplicand, mac_stall,
      output busy, done, dot_result, dot_protect, dot_overflow
   );

   modport master (
      output start, len, mode, sat, in_valid, in_a, in_b,
      output mac_result, mac_protect,
      input  in_ready,
      input  mac_instruction, mac_multiplier, mac_multiplicand, mac_stall,
      input  busy, done, dot_result, dot_protect, dot_overflow
   );

endinterface

// File: rtl/mac_dot_seq_lat_tag.sv
// Fixed-depth 1-bit tag delay matching a MAC pipeline; tag_out rises DEPTH
// cycles after tag_in was registered.
module mac_lat_tag
   import mac_dot_seq_pkg::*;
#(
   parameter int DEPTH = MAC_LAT_DEF
) (
   input  logic clk,
   input  logic reset_n,
   input  logic tag_in,
   output logic tag_out
);

   logic [DEPTH-1:0] sr_q;

   generate
      if (DEPTH == 1) begin : g_single
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) sr_q <= '0;
            else          sr_q <= tag_in;
         end
      end else begin : g_multi
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) sr_q <= '0;
            else          sr_q <= {sr_q[DEPTH-2:0], tag_in};
         end
      end
   endgenerate

   assign tag_out = sr_q[DEPTH-1];

endmodule

// File: rtl/mac_dot_seq.sv
// Dot-product sequencer: feeds LOAD/ACC/SAT to the MAC, follows the last op
// through the MAC latency and captures the final {protect,result}.
//
// state  | meaning
// IDLE   | waiting for start; MAC held in CLR
// LOAD   | accepting first pair (LOAD op)
// ACC    | accepting remaining pairs; zero-operand ACC on starvation
// SAT    | single SAT op after the last pair
// WAIT   | zero ACC bubbles until the last tag reaches the result port
module mac_dot_seq
   import mac_dot_seq_pkg::*;
#(
   parameter int LEN_W   = 8,
   parameter int MAC_LAT = MAC_LAT_DEF
) (
   input logic          clk,
   input logic          reset_n,
   mac_dot_seq_if.slave bus
);

   state_t           state_q, state_d;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic             mode_q, mode_d;
   logic             sat_q, sat_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             last_q, last_d;
   logic [2:0]       instr_q, instr_d;
   logic [15:0]      mult_q, mult_d;
   logic [15:0]      mcand_q, mcand_d;
   logic [31:0]      res_q;
   logic [7:0]       prot_q;
   logic             ovf_q;
   logic             in_ready;
   logic             accept;
   logic             zero_cmd;
   logic             tag_out;

   assign in_ready = (state_q == S_LOAD) || (state_q == S_ACC);
   assign accept   = bus.in_valid & in_ready;
   assign zero_cmd = (state_q == S_IDLE) & bus.start & (bus.len == '0);

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      mode_d  = mode_q;
      sat_d   = sat_q;
      busy_d  = busy_q;
      last_d  = 1'b0;
      instr_d = {mode_q, OP_ACC};
      mult_d  = '0;
      mcand_d = '0;
      done_d  = tag_out | zero_cmd;

      case (state_q)
         S_IDLE: begin
            instr_d = {mode_q, OP_CLR};
            if (bus.start && (bus.len != '0)) begin
               rem_d   = bus.len;
               mode_d  = bus.mode;
               sat_d   = bus.sat;
               busy_d  = 1'b1;
               state_d = S_LOAD;
            end
         end
         S_LOAD, S_ACC: begin
            if (accept) begin
               instr_d = {mode_q, (state_q == S_LOAD) ? OP_LOAD : OP_ACC};
               mult_d  = bus.in_a;
               mcand_d = bus.in_b;
               rem_d   = rem_q - LEN_W'(1);
               if (rem_q == LEN_W'(1)) begin
                  last_d  = ~sat_q;
                  state_d = sat_q ? S_SAT : S_WAIT;
               end else begin
                  state_d = S_ACC;
               end
            end else if (state_q == S_LOAD) begin
               // nothing accumulated yet, keep the MAC cleared
               instr_d = {mode_q, OP_CLR};
            end
         end
         S_SAT: begin
            instr_d = {mode_q, OP_SAT};
            last_d  = 1'b1;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (tag_out) begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         rem_q   <= '0;
         mode_q  <= 1'b0;
         sat_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         last_q  <= 1'b0;
         instr_q <= '0;
         mult_q  <= '0;
         mcand_q <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         mode_q  <= mode_d;
         sat_q   <= sat_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         last_q  <= last_d;
         instr_q <= instr_d;
         mult_q  <= mult_d;
         mcand_q <= mcand_d;
      end
   end

   // last_q is high while the final op sits on the MAC ports, so the tag
   // leaves the delay line exactly when that op's result is visible
   mac_lat_tag #(.DEPTH(MAC_LAT)) u_tag (
      .clk     (clk),
      .reset_n (reset_n),
      .tag_in  (last_q),
      .tag_out (tag_out)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         res_q  <= '0;
         prot_q <= '0;
         ovf_q  <= 1'b0;
      end else if (tag_out) begin
         res_q  <= bus.mac_result;
         prot_q <= bus.mac_protect;
         ovf_q  <= ovf_calc(mode_q, bus.mac_result, bus.mac_protect);
      end else if (zero_cmd) begin
         res_q  <= '0;
         prot_q <= '0;
         ovf_q  <= 1'b0;
      end
   end

   assign bus.in_ready         = in_ready;
   assign bus.mac_instruction  = instr_q;
   assign bus.mac_multiplier   = mult_q;
   assign bus.mac_multiplicand = mcand_q;
   assign bus.mac_stall        = 1'b0;
   assign bus.busy             = busy_q;
   assign bus.done             = done_q;
   assign bus.dot_result       = res_q;
   assign bus.dot_protect      = prot_q;
   assign bus.dot_overflow     = ovf_q;

endmodule

// File: doc/mac_dot_seq.md
Name: mac_dot_seq

Overview:
Dot-product sequencer that sits directly upstream of the MAC datapath and also collects what it produces.
- Takes a command (length, precision mode, saturate flag) and a stream of operand pairs over a valid/ready handshake.
- Drives the MAC instruction and operand ports: one LOAD, then ACCs, then an optional SAT.
- Tracks the MAC pipeline latency, captures the final {protect,result}, flags overflow and pulses done.

Parameters:
- LEN_W, 8: width of the vector-length field; maximum length is 2^LEN_W-1 pairs.
- MAC_LAT, 3: cycles from an instruction being presented on the mac_* outputs to its effect being visible on mac_result/mac_protect.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset; asynchronous, active-low
- start  in  1  command strobe; sampled only in IDLE
- len  in  LEN_W  number of operand pairs
- mode  in  1  0 = one 16x16 MAC; 1 = dual 8x8 lanes
- sat  in  1  1 = issue SAT after the last pair
- in_valid  in  1  operand pair valid
- in_ready  out  1  sequencer can accept a pair
- in_a  in  16  signed operand A
- in_b  in  16  signed operand B
- mac_instruction  out  3  {mode, op}; op: 00 CLR, 01 LOAD, 10 ACC, 11 SAT
- mac_multiplier  out  16  to MAC
- mac_multiplicand  out  16  to MAC
- mac_stall  out  1  tied 0
- mac_result  in  32  from MAC
- mac_protect  in  8  from MAC guard bits
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse
- dot_result  out  32  captured result, held until the next done
- dot_protect  out  8  captured guard bits
- dot_overflow  out  1  overflow flag of the captured value

Behaviour:
- Reset (async, any state, including mid-vector):
  - state = IDLE, tag pipe and counters cleared.
  - All outputs 0; mac_instruction = 000 (CLR).
- Register timing:
  - mac_* outputs are registered.
  - A pair accepted (in_valid & in_ready) at edge t is presented on the mac_* ports from t until the next edge.
- State machine:
  - IDLE: in_ready=0; issue {mode_reg,00} with operands 0.
    - start=1 & len!=0: latch len/mode/sat; remaining=len; busy=1; go to LOAD.
    - start=1 & len=0: next cycle dot_result/dot_protect/dot_overflow = 0 and done=1; stay IDLE.
  - LOAD: in_ready=1.
    - On accept: issue {mode,01} with in_a/in_b; remaining--.
    - Next state is ACC if remaining>0; else SAT if sat, else WAIT.
    - No accept: issue CLR with zero operands (nothing has started).
  - ACC: in_ready=1.
    - On accept: issue {mode,10}; remaining--.
    - No accept (starvation bubble): issue {mode,10} with zero operands. This adds 0, so the accumulator is unchanged.
    - Leave when remaining reaches 0: go to SAT if sat, else WAIT.
  - SAT: in_ready=0; issue {mode,11} once with operands 0; go to WAIT.
  - WAIT: in_ready=0; issue CLR-free bubbles (ACC with zero operands) until the capture below.
- Last tag and capture:
  - The final issued op (last pair, or the SAT op) carries a "last" tag into a MAC_LAT-deep shift register.
  - When the tag exits, capture mac_result→dot_result and mac_protect→dot_protect on that edge, and compute dot_overflow.
  - In the following cycle: done=1, busy=0, state=IDLE.
  - Ops issued after the tagged op never affect the captured value.
- Overflow rule:
  - mode 0: overflow when dot_protect is not the 8-bit sign extension of dot_result[31].
  - mode 1: lane0 = {protect[3:0], result[15:0]}; lane1 = {protect[7:4], result[31:16]}. Overflow when either lane's 4 guard bits are not the sign extension of that lane's bit 15.
- Arithmetic is unchanged by SAT: only result bits saturate; guard bits are preserved, so overflow is still reported after SAT.
- start while busy is ignored. in_ready is never high outside LOAD/ACC.

Decomposition:
- Shared package:
  - op encodings OP_CLR/OP_LOAD/OP_ACC/OP_SAT;
  - FSM state enum;
  - MAC_LAT default;
  - lane guard-bit positions.
- Sub-module mac_lat_tag: a MAC_LAT-deep, 1-bit shift register with async clear. Reused by any other MAC client.

Test Plan:
- 16-bit accumulate: mode=0, sat=0, len=3, pairs (3,4), (-2,5), (100,100) → dot_result=10002, dot_protect=0x00, overflow=0; done exactly MAC_LAT+1 cycles after the last pair is presented.
- Overflow with and without SAT: mode=0, len=4, each pair (32767,32767).
  - sat=0 → dot_result=0xFFFC0004, dot_protect=0x00, overflow=1.
  - sat=1 → dot_result=0x7FFFFFFF, overflow=1.
- Dual lane: mode=1, len=2, pairs (0x0302,0x0405) and (0xFF01,0x0203).
  - lane0 = 10+3 = 13; lane1 = 12-2 = 10.
  - → dot_result=0x000A000D, dot_protect=0x00, overflow=0.
- Starvation: repeat the first test with in_valid low for 2 cycles between pairs → identical dot_result; done delayed by 2 cycles.
- Boundaries:
  - start with len=0 → done the next cycle with result 0 and no LOAD issued.
  - start during busy → ignored, busy unchanged.
- Reset mid-vector: assert reset_n low after 1 of 3 pairs → all outputs 0 immediately, no done pulse; a new command afterwards produces a correct result.
